// File: rtl/pix_serial_link.sv
// Camera byte stream -> PIX_W-bit pixels -> FIFO -> UART-style serial line.
// Serial state advances only on ser_en ticks; Serot idles high.
module pix_serial_link #(
  parameter int PIX_W         = 12,
  parameter int BYTES_PER_PIX = 2,
  parameter int FIFO_DEPTH    = 16,
  parameter int LSB_FIRST     = 0
) (
  input  logic                          clk,
  input  logic                          nRst,
  input  logic                          VSYNC,
  input  logic                          HREF,
  input  logic [7:0]                    pixdata,
  input  logic                          ser_en,
  output logic                          Serot,
  output logic                          Wrtcmplt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          busy
);

  localparam int AW  = 8 * BYTES_PER_PIX;
  localparam int BCW = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;
  localparam int CW  = (PIX_W > 1) ? $clog2(PIX_W) : 1;

  typedef enum logic [1:0] {IDLE, DATA, STOP} st_t;

  // ---------------- byte assembly ----------------
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW+7:0]    acc_ext;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             push_q, push_d;
  logic             vs_q;
  logic             active, last_byte;
  logic             unused_acc;

  assign acc_ext    = {acc_q, pixdata};
  assign active     = HREF & ~VSYNC;
  assign last_byte  = (bcnt_q == BCW'(BYTES_PER_PIX - 1));
  // Bytes above the pixel width are deliberately dropped.
  assign unused_acc = ^acc_ext[AW+7:PIX_W];

  always_comb begin
    acc_d  = acc_q;
    bcnt_d = bcnt_q;
    pix_d  = pix_q;
    push_d = 1'b0;
    if (active) begin
      acc_d = acc_ext[AW-1:0];
      if (last_byte) begin
        pix_d  = acc_ext[PIX_W-1:0];
        push_d = 1'b1;
        bcnt_d = '0;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end else begin
      bcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      acc_q  <= '0;
      bcnt_q <= '0;
      pix_q  <= '0;
      push_q <= 1'b0;
      vs_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      bcnt_q <= bcnt_d;
      pix_q  <= pix_d;
      push_q <= push_d;
      vs_q   <= VSYNC;
    end
  end

  // ---------------- pixel FIFO ----------------
  logic [PIX_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             pop, full, do_push, drop, vs_rise;

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign do_push = push_q & (~full | pop);
  assign drop    = push_q & full & ~pop;
  assign vs_rise = VSYNC & ~vs_q;

  always_comb begin
    level_d = level_q;
    case ({do_push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (vs_rise) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= pix_q;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---------------- serial FSM ----------------
  st_t              state_q, state_d;
  logic [PIX_W-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic             serot_q, serot_d;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      serot_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      serot_q <= serot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ser_en) begin
      case (state_q)
        IDLE:    if (level_q != '0) state_d = DATA;
        DATA:    if (bit_q == CW'(PIX_W - 1)) state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pop     = 1'b0;
    shift_d = shift_q;
    bit_d   = bit_q;
    serot_d = serot_q;
    if (ser_en) begin
      case (state_q)
        IDLE: begin
          serot_d = 1'b1;
          if (level_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            serot_d = 1'b0;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (LSB_FIRST != 0) begin
            serot_d = shift_q[0];
            shift_d = shift_q >> 1;
          end else begin
            serot_d = shift_q[PIX_W-1];
            shift_d = shift_q << 1;
          end
          bit_d = bit_q + 1'b1;
        end
        STOP:    serot_d = 1'b1;
        default: serot_d = 1'b1;
      endcase
    end
  end

  assign Serot      = serot_q;
  assign Wrtcmplt   = push_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pix_serial_link.sv
// Randomized bench: queue-based reference model feeds expected pixels to a
// serial-line decoder monitor for an MSB-first and an LSB-first instance.
module tb_pix_serial_link;
  localparam int PIX_W = 12;
  localparam int BPP   = 2;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0, nRst = 1'b1, VSYNC = 1'b0, HREF = 1'b0, ser_en = 1'b0;
  logic [7:0] pixdata = 8'h00;
  logic ser0, ser1, wc0, wc1, ovf0, ovf1, busy0, busy1;
  logic [LW-1:0] lvl0, lvl1;

  pix_serial_link #(.PIX_W(PIX_W), .BYTES_PER_PIX(BPP), .FIFO_DEPTH(DEPTH), .LSB_FIRST(0)) u_msb (
    .clk(clk), .nRst(nRst), .VSYNC(VSYNC), .HREF(HREF), .pixdata(pixdata), .ser_en(ser_en),
    .Serot(ser0), .Wrtcmplt(wc0), .fifo_level(lvl0), .overflow(ovf0), .busy(busy0));

  pix_serial_link #(.PIX_W(PIX_W), .BYTES_PER_PIX(BPP), .FIFO_DEPTH(DEPTH), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .nRst(nRst), .VSYNC(VSYNC), .HREF(HREF), .pixdata(pixdata), .ser_en(ser_en),
    .Serot(ser1), .Wrtcmplt(wc1), .fifo_level(lvl1), .overflow(ovf1), .busy(busy1));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // ---------------- reference model ----------------
  int  mq[$];
  int  exp0[$], exp1[$];
  int  bytes_q[$];
  bit  push_pend = 0;
  int  push_pix  = 0;
  bit  m_ovf     = 0;
  bit  vs_prev   = 0;
  int  bt        = 0;   // ticks until the line is free for the next word
  int  cyc       = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin : model
    bit pop_now, rise, drop;
    int p, v;
    if (!nRst) begin
      mq.delete(); exp0.delete(); exp1.delete(); bytes_q.delete();
      push_pend = 0; m_ovf = 0; vs_prev = 0; bt = 0;
    end else begin
      pop_now = ser_en && (bt == 0) && (mq.size() > 0);
      rise    = VSYNC && !vs_prev;
      drop    = 0;
      if (ser_en && bt > 0) bt--;
      if (pop_now) begin
        p = mq.pop_front();
        exp0.push_back(p);
        exp1.push_back(p);
        bt = PIX_W + 1;
      end
      if (push_pend) begin
        if (mq.size() < DEPTH) mq.push_back(push_pix);
        else drop = 1;
      end
      if (drop)      m_ovf = 1;
      else if (rise) m_ovf = 0;
      push_pend = 0;
      if (HREF && !VSYNC) begin
        bytes_q.push_back(int'(pixdata));
        if (bytes_q.size() == BPP) begin
          v = 0;
          foreach (bytes_q[k]) v = (v << 8) | bytes_q[k];
          push_pix  = v & ((1 << PIX_W) - 1);
          push_pend = 1;
          bytes_q.delete();
        end
      end else begin
        bytes_q.delete();
      end
      vs_prev = VSYNC;
    end
  end

  // ---------------- monitor ----------------
  logic tick_seen = 1'b0;
  bit   chk_en = 0;
  bit   b2b = 0;
  int   last_start = -1;
  int   ph[2], nb[2], wd[2];
  bit   last_s[2];

  always @(posedge clk) tick_seen <= ser_en;

  always @(negedge clk) begin : mon
    bit s, bz;
    int e;
    if (!nRst) begin
      for (int i = 0; i < 2; i++) begin ph[i] = 0; nb[i] = 0; wd[i] = 0; last_s[i] = 1; end
    end else if (chk_en) begin
      chk("fifo_level", lvl0, mq.size());
      chk("fifo_level_lsb", lvl1, mq.size());
      chk("overflow", ovf0, m_ovf);
      chk("overflow_lsb", ovf1, m_ovf);
      chk("Wrtcmplt", wc0, push_pend);
      chk("Wrtcmplt_lsb", wc1, push_pend);
      for (int i = 0; i < 2; i++) begin
        s  = (i == 0) ? ser0 : ser1;
        bz = (i == 0) ? busy0 : busy1;
        if (!tick_seen) begin
          chk("serot_hold", s, last_s[i]);
        end else begin
          case (ph[i])
            0: if (!s) begin
                 ph[i] = 1; nb[i] = 0; wd[i] = 0;
                 if (i == 0 && b2b) begin
                   if (last_start >= 0) chk("b2b_word_clks", cyc - last_start, PIX_W + 2);
                   last_start = cyc;
                 end
               end
            1: begin
                 if (i == 0) wd[i] = (wd[i] << 1) | int'(s);
                 else        wd[i] = wd[i] | (int'(s) << nb[i]);
                 nb[i]++;
                 if (nb[i] == PIX_W) begin
                   ph[i] = 2;
                   if (i == 0) begin
                     chk("frame_pending", exp0.size() > 0, 1);
                     if (exp0.size() > 0) begin e = exp0.pop_front(); chk("pixel_msb", wd[i], e); end
                   end else begin
                     chk("frame_pending_lsb", exp1.size() > 0, 1);
                     if (exp1.size() > 0) begin e = exp1.pop_front(); chk("pixel_lsb", wd[i], e); end
                   end
                 end
               end
            default: begin chk("stop_bit", s, 1); ph[i] = 0; end
          endcase
        end
        chk("busy", bz, ph[i] != 0);
        last_s[i] = s;
      end
    end
  end

  // ---------------- stimulus ----------------
  int ser_mode = 0;

  always @(posedge clk) begin
    #1;
    case (ser_mode)
      1:       ser_en = (cyc % 4 == 0);
      2:       ser_en = 1'b1;
      3:       ser_en = ($urandom_range(0, 2) == 0);
      default: ser_en = 1'b0;
    endcase
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_px(input logic [7:0] b0, input logic [7:0] b1);
    HREF = 1'b1; pixdata = b0; step();
    pixdata = b1; step();
    HREF = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((mq.size() > 0 || bt > 0 || push_pend || busy0) && n < maxc) begin step(); n++; end
    if (n >= maxc) fail("drain_timeout");
  endtask

  initial begin
    int n;
    #3 nRst = 1'b0;
    #1;
    chk("rst_Serot", ser0, 1); chk("rst_Serot_lsb", ser1, 1);
    chk("rst_busy", busy0, 0); chk("rst_level", lvl0, 0);
    chk("rst_overflow", ovf0, 0); chk("rst_Wrtcmplt", wc0, 0);
    repeat (3) step();
    nRst = 1'b1; chk_en = 1;

    ser_mode = 1;
    repeat (20) step();

    send_px(8'hA5, 8'h3C);
    drain(400);

    HREF = 1'b1; pixdata = 8'hFF; step();
    HREF = 1'b0; step();
    send_px(8'h12, 8'h34);
    drain(400);

    ser_mode = 3;
    repeat (300) begin
      HREF    = ($urandom_range(0, 3) != 0);
      VSYNC   = ($urandom_range(0, 19) == 0);
      pixdata = 8'($urandom);
      step();
    end
    HREF = 1'b0; VSYNC = 1'b0;
    drain(3000);

    ser_mode = 0; step();
    HREF = 1'b1;
    repeat (2 * (DEPTH + 1)) begin pixdata = 8'($urandom); step(); end
    HREF = 1'b0;
    repeat (2) step();
    chk("full_level", lvl0, DEPTH); chk("full_overflow", ovf0, 1);
    VSYNC = 1'b1; step();
    VSYNC = 1'b0; step();
    chk("vs_clr_overflow", ovf0, 0); chk("vs_keep_level", lvl0, DEPTH);
    b2b = 1; last_start = -1; ser_mode = 2;
    drain(DEPTH * (PIX_W + 2) + 50);
    b2b = 0;

    send_px(8'h0F, 8'hED); send_px(8'h01, 8'h23); send_px(8'h04, 8'h56);
    n = 0;
    while (!busy0 && n < 50) begin step(); n++; end
    if (n >= 50) fail("wait_busy");
    repeat (5) step();
    nRst = 1'b0;
    #1;
    chk("midrst_Serot", ser0, 1); chk("midrst_Serot_lsb", ser1, 1);
    chk("midrst_busy", busy0, 0); chk("midrst_level", lvl0, 0);
    repeat (2) step();
    nRst = 1'b1;
    send_px(8'h0A, 8'hBC);
    drain(400);
    repeat (3) step();

    chk("exp_left_msb", exp0.size(), 0);
    chk("exp_left_lsb", exp1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pix_serial_link.md
Name: pix_serial_link

Overview:
- Parametrised successor to the capture-to-serial path.
- Samples camera bytes on VSYNC/HREF framing and assembles them into PIX_W-bit pixels.
- Buffers the pixels in a FIFO of FIFO_DEPTH entries and shifts them out on a single serial line, UART-style framed (start bit, data bits, stop bit), paced by a bit-tick enable.
- Sits between the camera interface and the off-chip serial receiver; replaces the fixed 12-bit, unbuffered, single-order transfer.

Parameters:
PIX_W, 12, pixel width in bits; 1 <= PIX_W <= 8*BYTES_PER_PIX
BYTES_PER_PIX, 2, camera bytes per pixel, 1..4
FIFO_DEPTH, 16, pixel FIFO entries, power of two, >= 2
LSB_FIRST, 0, 0 = data bits sent MSB first, 1 = LSB first

Ports:
clk  in  1  single clock, pixel clock domain; all logic on its rising edge
nRst  in  1  asynchronous active-low reset
VSYNC  in  1  frame sync, high = vertical blanking
HREF  in  1  line valid, high = pixdata valid on this clk
pixdata  in  8  camera byte
ser_en  in  1  one-clk bit-tick strobe; serial FSM advances only when high
Serot  out  1  serial data, idle high
Wrtcmplt  out  1  one-clk pulse per assembled pixel
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a pixel was dropped because the FIFO was full
busy  out  1  high while a word is on the line (state != IDLE)

Behaviour:
Reset (nRst low, async, also mid-word):
- Serot=1; Wrtcmplt=0; fifo_level=0; overflow=0; busy=0.
- FIFO emptied, byte counter=0, FSM=IDLE.
- Serot returns to 1 immediately on reset assertion.

Byte assembly:
- Active only when HREF=1 and VSYNC=0: each clk, acc <= {acc, pixdata}; byte_cnt increments.
- On byte_cnt == BYTES_PER_PIX-1: pixel = low PIX_W bits of acc including the current byte. The first byte is most significant; bits above PIX_W are discarded.
- Push is requested on the next clk; Wrtcmplt=1 for exactly that clk; byte_cnt wraps to 0.
- HREF=0 or VSYNC=1 resets byte_cnt to 0 and discards any partial pixel.
- Wrtcmplt pulses even when the push is dropped.

FIFO:
- Push while full (and no same-cycle pop): pixel dropped, overflow <= 1.
- Push and pop in the same cycle: both happen, level unchanged. This is legal when full.
- overflow clears only on a VSYNC rising edge (VSYNC registered once; rise = VSYNC & ~VSYNC_q) or on reset. A drop in the same cycle as the rise leaves overflow=1.
- The FIFO is never flushed by VSYNC.
- fifo_level is exact, registered, and updates the clk after push/pop.

Serial FSM (states IDLE, DATA, STOP; transitions only on clk with ser_en=1):
- IDLE: Serot=1. If FIFO is non-empty: pop into shift register, Serot<=0 (start bit), bit_cnt=0, go to DATA. Otherwise stay in IDLE.
- DATA: Serot <= next bit (MSB first, or LSB first if LSB_FIRST=1); bit_cnt++. After PIX_W bits, go to STOP.
- STOP: Serot<=1, go to IDLE.
- Each word occupies PIX_W+2 ticks.
- Back-to-back words: the stop bit lasts exactly one tick, then the next start bit follows on the next tick.
- Serot changes only on clk edges where ser_en=1 (or on reset).
- ser_en held constantly high is legal: one bit per clk.
- busy=1 from the start-bit edge until the STOP->IDLE edge.

Test Plan:
- Reset then idle with ser_en pulsing: Serot=1, busy=0, fifo_level=0 throughout.
- Defaults; VSYNC=0, HREF=1 for 2 clks with pixdata A5 then 3C, ser_en every 4 clks -> Wrtcmplt one pulse, fifo_level 1->0, Serot ticks: 0, 0101 0011 1100, 1 (pixel 12'h53C).
- LSB_FIRST=1, same input -> data ticks 0011 1100 1010 after the start bit; stop bit 1.
- HREF drops after 1 byte, then 2 full bytes 12 34 -> only one pixel 12'h234 pushed; partial byte discarded.
- ser_en=0, push 17 pixels at FIFO_DEPTH=16 -> fifo_level=16, overflow=1 after 17th; VSYNC rise -> overflow=0, fifo_level still 16; then ser_en constantly high -> 16 words back-to-back, each exactly 14 clks.
- nRst asserted mid DATA bit 5 -> Serot=1, busy=0, fifo_level=0 immediately; after release, first new pixel transmits with a clean start bit.
